// File: rtl/clipper_fan_ctrl.sv
// Board fan controller: PWM drive per fan, plus debounced tach edge counting over a fixed window with stall detection.
// Optional build macro CLIPPER_FAN_FAILSAFE_EN: any stall forces every fan to full speed while enabled.
module clipper_fan_ctrl #(
  parameter int NB_FANS    = 2,
  parameter int PWM_DIV    = 195,
  parameter int DEB_CYC    = 16,
  parameter int WIN_CYC    = 125000000,
  parameter int SPINUP_WIN = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable_i,
  input  logic [8*NB_FANS-1:0]    duty_i,
  input  logic [15:0]             tach_min_i,
  input  logic [NB_FANS-1:0]      stall_clr_i,
  output logic                    fan_enable,
  output logic [NB_FANS-1:0]      fan_ctrl,
  input  logic [NB_FANS-1:0]      fan_tach,
  output logic [16*NB_FANS-1:0]   tach_count,
  output logic                    tach_valid,
  output logic [NB_FANS-1:0]      fan_stall,
  output logic                    fan_irq
);

  localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int DEB_W  = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int WIN_W  = $clog2(WIN_CYC);
  localparam int SPIN_W = (SPINUP_WIN > 0) ? $clog2(SPINUP_WIN + 1) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PWM_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_CYC - 1);
  localparam logic [SPIN_W-1:0] SPIN_LOAD = SPIN_W'(SPINUP_WIN);

  logic [PRE_W-1:0]   pre_cnt;
  logic               pwm_tick;
  logic               pwm_wrap;
  logic [7:0]         pwm_cnt;
  logic [7:0]         duty_q [NB_FANS];
  logic [NB_FANS-1:0] pwm_on;
  logic               force_full;

  logic [NB_FANS-1:0] sync1;
  logic [NB_FANS-1:0] sync2;
  logic [NB_FANS-1:0] filt;
  logic [DEB_W-1:0]   deb_cnt [NB_FANS];
  logic [NB_FANS-1:0] deb_accept;
  logic [NB_FANS-1:0] tach_rise;
  logic [15:0]        edge_cnt  [NB_FANS];
  logic [15:0]        edge_next [NB_FANS];

  logic [WIN_W-1:0]   win_cnt;
  logic               win_end;
  logic [SPIN_W-1:0]  spin_cnt;
  logic               en_rise;
  logic [NB_FANS-1:0] stall_set;

  assign pwm_tick = (pre_cnt == PRE_LAST);
  assign pwm_wrap = pwm_tick && (pwm_cnt == 8'hFF);
  assign win_end  = (win_cnt == WIN_LAST);
  // fan_enable is the previous-cycle enable_i, so it doubles as the edge detector history.
  assign en_rise  = enable_i & ~fan_enable;

`ifdef CLIPPER_FAN_FAILSAFE_EN
  assign force_full = |fan_stall;
`else
  assign force_full = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < NB_FANS; i++) begin
      pwm_on[i]     = (duty_q[i] == 8'hFF) || (pwm_cnt < duty_q[i]);
      deb_accept[i] = (sync2[i] != filt[i]) && (deb_cnt[i] == DEB_LAST);
      tach_rise[i]  = deb_accept[i] & sync2[i];
      // Count an edge accepted on the window's last cycle into that window.
      edge_next[i]  = (tach_rise[i] && (edge_cnt[i] != 16'hFFFF)) ? edge_cnt[i] + 16'd1
                                                                   : edge_cnt[i];
      stall_set[i]  = win_end && enable_i && (duty_q[i] != 8'd0) && (spin_cnt == '0) &&
                      (edge_next[i] < tach_min_i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt    <= '0;
      pwm_cnt    <= '0;
      fan_enable <= 1'b0;
      fan_ctrl   <= '0;
      for (int i = 0; i < NB_FANS; i++) duty_q[i] <= '0;
    end else begin
      fan_enable <= enable_i;
      pre_cnt    <= pwm_tick ? '0 : pre_cnt + PRE_W'(1);
      if (pwm_tick) pwm_cnt <= pwm_cnt + 8'd1;
      for (int i = 0; i < NB_FANS; i++) begin
        if (pwm_wrap) duty_q[i] <= duty_i[8*i +: 8];
      end
      fan_ctrl <= {NB_FANS{enable_i}} & (pwm_on | {NB_FANS{force_full}});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < NB_FANS; i++) begin
        deb_cnt[i]  <= '0;
        edge_cnt[i] <= '0;
      end
    end else begin
      sync1 <= fan_tach;
      sync2 <= sync1;
      for (int i = 0; i < NB_FANS; i++) begin
        if (sync2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_accept[i]) begin
          deb_cnt[i] <= '0;
          filt[i]    <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
        edge_cnt[i] <= win_end ? 16'd0 : edge_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt    <= '0;
      spin_cnt   <= '0;
      tach_count <= '0;
      tach_valid <= 1'b0;
      fan_stall  <= '0;
      fan_irq    <= 1'b0;
    end else begin
      win_cnt    <= win_end ? '0 : win_cnt + WIN_W'(1);
      tach_valid <= win_end;
      if (en_rise) begin
        spin_cnt <= SPIN_LOAD;
      end else if (win_end && (spin_cnt != '0)) begin
        spin_cnt <= spin_cnt - SPIN_W'(1);
      end
      for (int i = 0; i < NB_FANS; i++) begin
        if (win_end) tach_count[16*i +: 16] <= edge_next[i];
      end
      // Set wins over a same-cycle clear.
      fan_stall <= (fan_stall & ~stall_clr_i) | stall_set;
      fan_irq   <= |fan_stall;
    end
  end

endmodule

// File: tb/tb_clipper_fan_ctrl.sv
// Self-checking bench for clipper_fan_ctrl: PWM duty, tach windowing, debounce, spin-up and sticky stall behaviour.
module tb_clipper_fan_ctrl;

  localparam int NB  = 2;
  localparam int WIN = 1000;
`ifdef CLIPPER_FAN_FAILSAFE_EN
  localparam bit FAILSAFE = 1'b1;
`else
  localparam bit FAILSAFE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable_i = 1'b0;
  logic [8*NB-1:0]   duty_i = '0;
  logic [15:0]       tach_min_i = '0;
  logic [NB-1:0]     stall_clr_i = '0;
  logic              fan_enable;
  logic [NB-1:0]     fan_ctrl;
  logic [NB-1:0]     fan_tach;
  logic [16*NB-1:0]  tach_count;
  logic              tach_valid;
  logic [NB-1:0]     fan_stall;
  logic              fan_irq;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  logic [15:0] exp_q[$];

  // Tach stimulus model: half-period in cycles (0 = stopped) and optional 2-cycle glitches.
  int   half [NB] = '{0, 0};
  int   ph [NB] = '{0, 0};
  int   gen_rises [NB] = '{0, 0};
  bit   glitch [NB] = '{1'b0, 1'b0};
  logic lvl [NB] = '{1'b0, 1'b0};
  logic [NB-1:0] raw;

  clipper_fan_ctrl #(
    .NB_FANS(NB), .PWM_DIV(1), .DEB_CYC(4), .WIN_CYC(WIN), .SPINUP_WIN(1)
  ) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .duty_i(duty_i),
    .tach_min_i(tach_min_i), .stall_clr_i(stall_clr_i), .fan_enable(fan_enable),
    .fan_ctrl(fan_ctrl), .fan_tach(fan_tach), .tach_count(tach_count),
    .tach_valid(tach_valid), .fan_stall(fan_stall), .fan_irq(fan_irq)
  );

  // Clock / reset / time base
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    fan_tach = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NB; i++) begin
        if (half[i] == 0) begin
          lvl[i] = 1'b0;
          ph[i]  = 0;
        end else begin
          ph[i]++;
          if (ph[i] >= half[i]) begin
            ph[i]  = 0;
            lvl[i] = ~lvl[i];
            if (lvl[i]) gen_rises[i]++;
          end
        end
        raw[i] = lvl[i] ^ (glitch[i] && (ph[i] == 8 || ph[i] == 9));
      end
      fan_tach = raw;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v,
                       input int tol);
    int d;
    d = int'(obs) - int'(exp_v);
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cyc %0d", tag, obs, exp_v, tol, cyc);
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(output int unsigned t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tach_valid && n < 1500);
    if (!tach_valid) check("valid_timeout", 32'd0, 32'd1, 0);
    t = cyc;
  endtask

  task automatic count_high2(output int h0, output int h1);
    h0 = 0;
    h1 = 0;
    for (int j = 0; j < 256; j++) begin
      h0 += int'(fan_ctrl[0]);
      h1 += int'(fan_ctrl[1]);
      tick(1);
    end
  endtask

  function automatic int hi_exp(input int d);
    return (d == 255) ? 256 : d;
  endfunction

  task automatic take_rises(output int g0, output int g1);
    g0 = gen_rises[0];
    g1 = gen_rises[1];
    gen_rises[0] = 0;
    gen_rises[1] = 0;
  endtask

  initial begin
    int unsigned t, t0;
    int h0, h1, d0, d1, g0, g1;
    logic prev, cur, found;
    int n;
    int hp [2];

    // Reset state
    tick(3);
    check("rst_fan_enable", fan_enable, 0, 0);
    check("rst_fan_ctrl", fan_ctrl, 0, 0);
    check("rst_tach_count", tach_count, 0, 0);
    check("rst_tach_valid", tach_valid, 0, 0);
    check("rst_fan_stall", fan_stall, 0, 0);
    check("rst_fan_irq", fan_irq, 0, 0);
    rst = 1'b1;
    t0 = cyc;
    wait_valid(t);
    check("first_window_len", t - t0, WIN, 0);

    // PWM duty across fixed and random values
    enable_i = 1'b1;
    tick(1);
    check("fan_enable_on", fan_enable, 1, 0);
    for (int k = 0; k < 5; k++) begin
      d0 = (k == 0) ? 64 : (k == 1) ? 0 : (k == 2) ? 255 : $urandom_range(1, 254);
      d1 = $urandom_range(0, 255);
      duty_i = {8'(d1), 8'(d0)};
      tick(520);
      count_high2(h0, h1);
      check("pwm_hi_fan0", h0, hi_exp(d0), 0);
      check("pwm_hi_fan1", h1, hi_exp(d1), 0);
    end
    enable_i = 1'b0;
    tick(1);
    check("disable_fan_ctrl", fan_ctrl, 0, 0);
    check("disable_fan_enable", fan_enable, 0, 0);
    tick(5);
    check("disable_hold", fan_ctrl, 0, 0);
    enable_i = 1'b1;

    // Duty change mid-period takes effect on the next period
    duty_i = {8'd32, 8'd64};
    tick(520);
    prev = fan_ctrl[0];
    found = 1'b0;
    n = 0;
    do begin
      tick(1);
      n++;
      cur = fan_ctrl[0];
      found = cur & ~prev;
      prev = cur;
    end while (!found && n < 600);
    check("pwm_rise_found", found, 1, 0);
    h0 = 0;
    h1 = 0;
    for (int j = 0; j < 512; j++) begin
      if (j == 100) duty_i[7:0] = 8'd128;
      if (j < 256) h0 += int'(fan_ctrl[0]);
      else         h1 += int'(fan_ctrl[0]);
      tick(1);
    end
    check("duty_cur_period", h0, 64, 0);
    check("duty_next_period", h1, 128, 0);

    // Tach counting with a clean wave on fan0 and a random rate on fan1
    hp[1] = $urandom_range(5, 25);
    half[0] = 10;
    half[1] = hp[1];
    wait_valid(t0);
    take_rises(g0, g1);
    for (int k = 0; k < 2; k++) begin
      wait_valid(t);
      take_rises(g0, g1);
      check("valid_period", t - t0, WIN, 0);
      check("tach0_nominal", tach_count[15:0], 50, 1);
      exp_q.push_back(16'(g0));
      exp_q.push_back(16'(g1));
      check("tach0_vs_gen", tach_count[15:0], exp_q.pop_front(), 1);
      check("tach1_vs_gen", tach_count[31:16], exp_q.pop_front(), 1);
      tick(1);
      check("valid_width", tach_valid, 0, 0);
      t0 = t;
    end

    // Glitches shorter than the debounce time are ignored
    half[0] = 20;
    glitch[0] = 1'b1;
    wait_valid(t);
    take_rises(g0, g1);
    wait_valid(t);
    take_rises(g0, g1);
    check("glitch_tach0_nominal", tach_count[15:0], 25, 1);
    check("glitch_tach0_vs_gen", tach_count[15:0], 32'(g0), 1);
    glitch[0] = 1'b0;
    half[0] = 10;

    // Spin-up suppression, stall set, irq lag, set beats clear
    tach_min_i = 16'd40;
    half[1] = 0;
    duty_i = {8'd100, 8'd64};
    enable_i = 1'b0;
    wait_valid(t);
    enable_i = 1'b1;
    wait_valid(t);
    check("spinup_no_stall", fan_stall, 0, 0);
    wait_valid(t);
    check("stall_set", fan_stall, 2, 0);
    check("stall_tach1_zero", tach_count[31:16], 0, 0);
    check("irq_lag", fan_irq, 0, 0);
    tick(1);
    check("irq_set", fan_irq, 1, 0);
    while (cyc != t + WIN - 1) tick(1);
    stall_clr_i = 2'b10;
    tick(1);
    stall_clr_i = '0;
    check("clr_on_win_end", tach_valid, 1, 0);
    check("set_beats_clr", fan_stall, 2, 0);
    count_high2(h0, h1);
    check("stalled_hi_fan0", h0, FAILSAFE ? 256 : 64, 0);
    check("stalled_hi_fan1", h1, FAILSAFE ? 256 : 100, 0);

    // Mid-window reset clears everything, including sticky stalls
    tick(300);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_fan_stall", fan_stall, 0, 0);
    check("mid_rst_fan_irq", fan_irq, 0, 0);
    check("mid_rst_fan_ctrl", fan_ctrl, 0, 0);
    check("mid_rst_fan_enable", fan_enable, 0, 0);
    check("mid_rst_tach_count", tach_count, 0, 0);
    check("mid_rst_tach_valid", tach_valid, 0, 0);
    tick(2);
    rst = 1'b1;
    t0 = cyc;
    wait_valid(t);
    check("post_rst_window_len", t - t0, WIN, 0);
    check("post_rst_spinup", fan_stall, 0, 0);
    wait_valid(t);
    check("post_rst_stall", fan_stall, 2, 0);
    tick(2);
    count_high2(h0, h1);
    check("forced_hi_fan0", h0, FAILSAFE ? 256 : 64, 0);
    check("forced_hi_fan1", h1, FAILSAFE ? 256 : 100, 0);

    // Fan1 recovers, stall cleared, normal PWM resumes
    half[1] = 10;
    wait_valid(t);
    take_rises(g0, g1);
    wait_valid(t);
    take_rises(g0, g1);
    check("recover_tach1", tach_count[31:16], 32'(g1), 1);
    check("recover_still_stalled", fan_stall, 2, 0);
    stall_clr_i = 2'b10;
    tick(1);
    stall_clr_i = '0;
    check("stall_cleared", fan_stall, 0, 0);
    tick(1);
    check("irq_cleared", fan_irq, 0, 0);
    tick(2);
    count_high2(h0, h1);
    check("resume_hi_fan0", h0, 64, 0);
    check("resume_hi_fan1", h1, 100, 0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clipper_fan_ctrl.md
Name: clipper_fan_ctrl

Overview:
- Board fan controller on the DUT side of the misc IO interface.
- Generates the fan_enable and per-fan PWM fan_ctrl outputs, and measures the per-fan fan_tach inputs.
- Tach is synchronized, debounced and counted over a fixed window. Each window result is compared against a stall threshold.
- Results feed the CPU register bank; fan_irq feeds the cpu_int_n aggregation logic.

Parameters:
- NB_FANS, 2, number of fans (matches clipper_pkg NB_FANS).
- PWM_DIV, 195, clk cycles per PWM step; PWM period = 256*PWM_DIV cycles.
- DEB_CYC, 16, consecutive stable cycles required to accept a tach level change (>=1).
- WIN_CYC, 125000000, tach measurement window length in clk cycles (>=2).
- SPINUP_WIN, 2, windows after enable rise during which stall evaluation is suppressed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset; asserted when 0.
- enable_i  in  1  global fan enable from the register bank.
- duty_i  in  8*NB_FANS  per-fan duty; fan i is duty_i[8i+7:8i]; 0 = off, 255 = full on.
- tach_min_i  in  16  stall threshold, in edges per window.
- stall_clr_i  in  NB_FANS  per-fan stall clear; one-cycle pulse.
- fan_enable  out  1  fan power enable.
- fan_ctrl  out  NB_FANS  PWM drive per fan.
- fan_tach  in  NB_FANS  asynchronous tach inputs.
- tach_count  out  16*NB_FANS  last completed window edge count per fan.
- tach_valid  out  1  one-cycle pulse when tach_count updates.
- fan_stall  out  NB_FANS  sticky per-fan stall flags.
- fan_irq  out  1  OR of fan_stall, registered.

Behaviour:
- Reset (rst=0, async):
  - All outputs are 0.
  - All counters are 0, duty registers are 0, debounced tach levels are 0, and the spin-up counter is 0.
- fan_enable is enable_i registered, one cycle latency.
- PWM:
  - A prescaler counts 0..PWM_DIV-1 and emits a tick on its last value.
  - pwm_cnt (8 bit) increments on each tick and wraps 255->0.
  - Duty registers load from duty_i only when pwm_cnt wraps to 0 on a tick. This gives glitch-free updates, which take effect from the next PWM period.
  - fan_ctrl[i] is registered: enable_i & ((duty_q[i]==255) | (pwm_cnt < duty_q[i])).
  - duty 0 gives constant 0; duty 255 gives constant 1; duty N gives a high time of N*PWM_DIV cycles per period.
  - enable_i=0 forces fan_ctrl to 0 on the next cycle. The PWM counters keep running.
- Tach input path:
  - Each fan_tach bit passes through a 2-FF synchronizer.
  - Debounce: a per-fan counter resets whenever the synchronized input equals the filtered level. Otherwise it increments.
  - When the counter reaches DEB_CYC-1, the filtered level takes the synchronized value.
  - A rising edge of the filtered level increments the per-fan edge counter, saturating at 16'hFFFF.
- Window:
  - A window counter runs 0..WIN_CYC-1 continuously, independent of enable_i.
  - On the last cycle, for each fan: tach_count <= edge count including any edge in that same cycle. The edge counter then restarts at 0. tach_valid pulses for exactly one cycle.
- Spin-up:
  - A rising edge of enable_i loads the spin-up counter with SPINUP_WIN.
  - It decrements at each window end while nonzero.
- Stall evaluation happens at window end only. fan_stall[i] sets when all of these hold:
  - enable_i=1,
  - duty_q[i]!=0,
  - spin-up counter == 0,
  - new count < tach_min_i.
- Stall flags are sticky and clear only via stall_clr_i[i].
- Set and clear in the same cycle: set wins.
- tach_min_i=0 never stalls.
- fan_irq = |fan_stall, registered, one cycle after the fan_stall change.
- Mid-operation reset clears all state immediately, including sticky stalls. After release, the first window starts at count 0.

Optional Feature:
- Macro: CLIPPER_FAN_FAILSAFE_EN.
- Defined: while any fan_stall bit is set and enable_i=1, every fan_ctrl is forced to 1 (full speed), starting the cycle after the stall flag sets. Normal PWM resumes the cycle after the last stall flag clears.
- Not defined: stall flags have no effect on fan_ctrl.

Test Plan:
- Bench parameters for all scenarios: PWM_DIV=1, DEB_CYC=4, WIN_CYC=1000, SPINUP_WIN=1.
1. enable_i=1, duty_i fan0=64 -> fan0 high 64 of every 256 cycles; duty 0 -> constant 0; duty 255 -> constant 1; enable_i=0 -> fan_ctrl=0 next cycle.
2. Change duty 64->128 mid-period -> the current period keeps 64 high cycles; the next period has 128.
3. Clean square wave on fan_tach[0] with period 20 cycles -> tach_count[0]=50 (+/-1) at each tach_valid; tach_valid pulse width is exactly 1 cycle and its period is 1000 cycles.
4. Tach with 2-cycle glitches between clean edges -> glitches are not counted and the count equals the clean edge count.
5. tach_min_i=40, fan1 stopped, enable rise -> no stall at the first window end (spin-up); fan_stall[1]=1 at the second window end; fan_irq=1 one cycle later. stall_clr_i[1] pulsed on the same cycle as a third stall window end -> flag stays 1.
6. With CLIPPER_FAN_FAILSAFE_EN and fan_stall[1]=1, duty 64 -> all fan_ctrl=1. Clear stall with fan1 now spinning -> PWM 64/256 resumes. Assert rst=0 mid-window -> all outputs 0 immediately.
